// File: rtl/alu_pipe_if.sv
// Operand-issue and result-return bundle for alu_pipe; valid/ready on both sides.
// The ALU takes the slave view; the issuing/consuming side takes the master view.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] a_dat;
  logic [WIDTH-1:0] b_dat;
  logic [3:0]       sel_dat;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_dat;
  logic             zero;
  logic             carry;
  logic             neg;
  logic             ovf;
  logic             err;

  modport master (
    output in_vld, a_dat, b_dat, sel_dat, out_rdy,
    input  in_rdy, out_vld, out_dat, zero, carry, neg, ovf, err
  );

  modport slave (
    input  in_vld, a_dat, b_dat, sel_dat, out_rdy,
    output in_rdy, out_vld, out_dat, zero, carry, neg, ovf, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: logic/add/sub/shift ops respond 1 cycle after accept, MUL after WIDTH cycles.
// A pending result holds Out/flags stable and drops in_rdy until the consumer takes it.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_pipe_if.slave  alu_s
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int M   = WIDTH - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               vld_q, vld_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               in_rdy_c;
  logic               accept_c;
  logic [WIDTH:0]     add_c;
  logic [WIDTH:0]     sub_c;
  logic [SHW-1:0]     sh_c;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c;
  logic               ovf_c;
  logic               legal_c;
  logic               mul_c;
  logic [2*WIDTH-1:0] acc_step_c;

  assign in_rdy_c = (state_q == ST_IDLE) && (!vld_q || alu_s.out_rdy);
  assign accept_c = alu_s.in_vld && in_rdy_c;

  assign add_c = {1'b0, alu_s.a_dat} + {1'b0, alu_s.b_dat};
  assign sub_c = {1'b0, alu_s.a_dat} - {1'b0, alu_s.b_dat};
  assign sh_c  = alu_s.b_dat[SHW-1:0];

  // Single-cycle datapath; res_c defaults to the held result so illegal ops change nothing.
  always_comb begin
    res_c   = out_q;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    legal_c = 1'b1;
    mul_c   = 1'b0;
    case (alu_s.sel_dat)
      OP_AND: res_c = alu_s.a_dat & alu_s.b_dat;
      OP_OR:  res_c = alu_s.a_dat | alu_s.b_dat;
      OP_XOR: res_c = alu_s.a_dat ^ alu_s.b_dat;
      OP_NOR: res_c = ~(alu_s.a_dat | alu_s.b_dat);
      OP_ADD: begin
        res_c   = add_c[M:0];
        carry_c = add_c[WIDTH];
        ovf_c   = (alu_s.a_dat[M] == alu_s.b_dat[M]) && (add_c[M] != alu_s.a_dat[M]);
      end
      OP_SUB: begin
        res_c   = sub_c[M:0];
        carry_c = sub_c[WIDTH];
        ovf_c   = (alu_s.a_dat[M] != alu_s.b_dat[M]) && (sub_c[M] != alu_s.a_dat[M]);
      end
      OP_SLT: res_c = {{M{1'b0}}, ($signed(alu_s.a_dat) < $signed(alu_s.b_dat))};
      OP_SLL: res_c = alu_s.a_dat << sh_c;
      OP_SRL: res_c = alu_s.a_dat >> sh_c;
      OP_SRA: res_c = WIDTH'($signed(alu_s.a_dat) >>> sh_c);
      OP_MUL: mul_c = 1'b1;
      default: legal_c = 1'b0;
    endcase
  end

  assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    vld_d    = vld_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (accept_c) begin
      err_d = !legal_c;
      if (mul_c) begin
        state_d  = ST_BUSY;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, alu_s.a_dat};
        mplier_d = alu_s.b_dat;
        cnt_d    = CW'(WIDTH);
        vld_d    = 1'b0;
      end else begin
        vld_d = 1'b1;
        if (legal_c) begin
          out_d   = res_c;
          zero_d  = (res_c == '0);
          carry_d = carry_c;
          neg_d   = res_c[M];
          ovf_d   = ovf_c;
        end
      end
    end else begin
      if (alu_s.out_rdy) begin
        vld_d = 1'b0;
      end
      if (state_q == ST_BUSY) begin
        acc_d    = acc_step_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last partial product lands on this edge, so the result uses the stepped accumulator.
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          out_d   = acc_step_c[M:0];
          zero_d  = (acc_step_c[M:0] == '0);
          carry_d = |acc_step_c[2*WIDTH-1:WIDTH];
          neg_d   = acc_step_c[M];
          ovf_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign alu_s.in_rdy  = in_rdy_c;
  assign alu_s.out_vld = vld_q;
  assign alu_s.out_dat = out_q;
  assign alu_s.zero    = zero_q;
  assign alu_s.carry   = carry_q;
  assign alu_s.neg     = neg_q;
  assign alu_s.ovf     = ovf_q;
  assign alu_s.err     = err_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: back-to-back vector table plus
// hand-written MUL, back-pressure, illegal-op and reset-abort sequences.
module tb_alu_pipe;
  localparam int W = 8;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1101;
  localparam logic [3:0] OP_BAD = 4'b0100;

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic [3:0]   zcnv;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   stale;
  vec_t vt[15];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .alu_s (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_vld  = 1'b1;
    bus.sel_dat = sel;
    bus.a_dat   = a;
    bus.b_dat   = b;
  endtask

  function automatic logic [3:0] flags();
    return {bus.zero, bus.carry, bus.neg, bus.ovf};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    // {sel, a, b, out, {zero, carry, negative, overflow}}
    vt[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1100};
    vt[1]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001};
    vt[2]  = '{OP_SRA, 8'h90, 8'h02, 8'hE4, 4'b0010};
    vt[3]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vt[4]  = '{OP_OR,  8'h0F, 8'hF0, 8'hFF, 4'b0010};
    vt[5]  = '{OP_XOR, 8'hFF, 8'h0F, 8'hF0, 4'b0010};
    vt[6]  = '{OP_NOR, 8'h0F, 8'hF0, 8'h00, 4'b1000};
    vt[7]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0011};
    vt[8]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 4'b0110};
    vt[9]  = '{OP_SLT, 8'hFF, 8'h01, 8'h01, 4'b0000};
    vt[10] = '{OP_SLT, 8'h05, 8'h03, 8'h00, 4'b1000};
    vt[11] = '{OP_SLL, 8'h01, 8'h0B, 8'h08, 4'b0000};
    vt[12] = '{OP_SRL, 8'h80, 8'h07, 8'h01, 4'b0000};
    vt[13] = '{OP_SRA, 8'h80, 8'hF9, 8'hC0, 4'b0010};
    vt[14] = '{OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1000};

    bus.in_vld  = 1'b0;
    bus.sel_dat = OP_AND;
    bus.a_dat   = '0;
    bus.b_dat   = '0;
    bus.out_rdy = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #2;
    chk("reset_out",   bus.out_dat, 8'h00);
    chk("reset_flags", {flags(), bus.err}, 5'b10000);
    chk("reset_hs",    {bus.out_vld, bus.in_rdy}, 2'b01);
    tick();
    tick();
    rst = 1'b0;

    // Back-to-back single-cycle ops with the consumer always ready.
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].sel, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_in_rdy", i), bus.in_rdy, 1'b1);
      tick();
      chk($sformatf("vec%0d_out", i), bus.out_dat, vt[i].out);
      chk($sformatf("vec%0d_flags", i), flags(), vt[i].zcnv);
      chk($sformatf("vec%0d_vld_err", i), {bus.out_vld, bus.err}, 2'b10);
    end
    bus.in_vld = 1'b0;
    tick();
    chk("drain_vld", bus.out_vld, 1'b0);

    // MUL 0x12*0x10 = 0x120; operands scrambled after accept.
    drive(OP_MUL, 8'h12, 8'h10);
    tick();
    bus.in_vld = 1'b0;
    bus.a_dat  = 8'hFF;
    bus.b_dat  = 8'hFF;
    for (int c = 0; c < W - 1; c++) begin
      chk($sformatf("mul_busy_c%0d", c), {bus.out_vld, bus.in_rdy}, 2'b00);
      tick();
    end
    chk("mul_busy_last", {bus.out_vld, bus.in_rdy}, 2'b00);
    tick();
    chk("mul_vld",   bus.out_vld, 1'b1);
    chk("mul_out",   bus.out_dat, 8'h20);
    chk("mul_flags", flags(), 4'b0100);
    tick();
    chk("mul_drain", bus.out_vld, 1'b0);

    // MUL without high-half overflow: 0x0F*0x0F = 0xE1.
    drive(OP_MUL, 8'h0F, 8'h0F);
    tick();
    bus.in_vld = 1'b0;
    repeat (W) tick();
    chk("mul2_out",   {bus.out_vld, bus.out_dat}, 9'h1E1);
    chk("mul2_flags", flags(), 4'b0010);
    tick();

    // Back-pressure: AND result held while an XOR waits.
    bus.out_rdy = 1'b0;
    drive(OP_AND, 8'hF0, 8'h3C);
    tick();
    drive(OP_XOR, 8'hAA, 8'hFF);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_hold_out_c%0d", c), {bus.out_vld, bus.out_dat}, 9'h130);
      chk($sformatf("bp_hold_rdy_c%0d", c), bus.in_rdy, 1'b0);
      tick();
    end
    chk("bp_hold_final", {bus.out_vld, bus.out_dat, flags()}, 13'h1300);
    bus.out_rdy = 1'b1;
    #1;
    chk("bp_release_rdy", bus.in_rdy, 1'b1);
    tick();
    chk("bp_xor", {bus.out_vld, bus.out_dat}, 9'h155);
    bus.in_vld = 1'b0;
    tick();
    chk("bp_drain", bus.out_vld, 1'b0);

    // Illegal opcode keeps the previous result and raises Err.
    drive(OP_OR, 8'h0F, 8'hF0);
    tick();
    chk("ill_pre", {bus.out_dat, bus.zero, bus.err}, 10'h3FC);
    drive(OP_BAD, 8'h00, 8'h00);
    tick();
    chk("ill_resp", {bus.out_vld, bus.out_dat, bus.zero, bus.err}, 11'h7FD);
    drive(OP_ADD, 8'h01, 8'h01);
    tick();
    chk("ill_clear", {bus.out_vld, bus.out_dat, bus.err}, 10'h204);
    bus.in_vld = 1'b0;
    tick();

    // Reset four cycles into a MUL aborts it.
    drive(OP_MUL, 8'h03, 8'h05);
    tick();
    bus.in_vld = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("rst_mul_hs",  {bus.out_vld, bus.in_rdy}, 2'b01);
    chk("rst_mul_out", {bus.out_dat, bus.zero}, 9'h001);
    tick();
    rst = 1'b0;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.out_vld) stale++;
    end
    chk("rst_mul_stale", stale, 0);
    drive(OP_ADD, 8'h03, 8'h04);
    tick();
    chk("rst_after_add", {bus.out_vld, bus.out_dat, flags()}, 13'h1070);
    bus.in_vld = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked ALU that succeeds the fixed 8-bit ALU. It has a configurable datapath width, a larger opcode set, and full status flags (Zero, Carry, Negative, Overflow, Err). Single-cycle operations issue back-to-back. An iterative shift-add multiplier takes WIDTH cycles. The block sits between an operand-issue stage and a result consumer, and uses valid/ready on both sides.

## Interface
- WIDTH, 8, datapath width; must be a power of two, ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- In_valid  in  1  operand/opcode presented.
- In_ready  out  1  block accepts an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; B[SHW-1:0] is the shift amount for shifts.
- Sel  in  4  opcode.
- Out_valid  out  1  result registered and pending.
- Out_ready  in  1  consumer takes the result this cycle.
- Out  out  WIDTH  result.
- Zero  out  1  Out == 0.
- Carry  out  1  carry / borrow / multiply-overflow, per opcode.
- Negative  out  1  Out[WIDTH-1].
- Overflow  out  1  signed overflow (ADD/SUB only).
- Err  out  1  the last accepted Sel was illegal.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0011 XOR, 1100 NOR.
  - 0010 ADD, 0110 SUB, 0111 SLT (signed A<B → 1, else 0).
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1101 MUL (low WIDTH bits of the product).
- Any other Sel is illegal.
- Carry rules:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: 1 when A < B unsigned (borrow).
  - MUL: 1 when the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other opcodes: 0.
- Overflow: signed overflow for ADD/SUB; 0 for all other opcodes.
- Shifts: use only B[SHW-1:0]; upper bits of B are ignored. SRA replicates A[WIDTH-1].
- Illegal Sel:
  - Out, Zero, Carry, Negative and Overflow retain their previous values.
  - Err = 1.
  - Out_valid still asserts: exactly one response per accepted operation.
- Err clears to 0 on the next accepted legal opcode.
- Accept condition: In_valid && In_ready at a rising edge.
- State machine:
  - IDLE → IDLE on accepting a non-MUL op; the result is registered with Out_valid = 1.
  - IDLE → BUSY on accepting MUL; operands and counter are loaded with count = WIDTH.
  - BUSY: one multiplier bit per cycle. When count reaches 0, load the result and flags, set Out_valid = 1, and return to IDLE.
- In_ready = (state == IDLE) && (!Out_valid || Out_ready). It is combinational and has no dependence on In_valid.
- Out_valid clears on Out_ready unless a new single-cycle op is accepted on the same edge. In that case Out/flags are replaced and Out_valid stays 1.

## Timing
- Reset values (asynchronous, immediate): Out = 0, Zero = 1, Carry = 0, Negative = 0, Overflow = 0, Err = 0, Out_valid = 0, state = IDLE. In_ready is therefore 1.
- Latency:
  - Single-cycle op accepted at edge k: Out_valid is high after edge k.
  - MUL accepted at edge k: Out_valid is high after edge k+WIDTH. In_ready is low from after edge k until the result is consumed.
- Throughput: one single-cycle op per clock while Out_ready is held high.
- Back-pressure: while Out_valid && !Out_ready, Out and all flags are stable and In_ready = 0.
- Out_ready while Out_valid = 0 has no effect.
- Rst during BUSY aborts the multiply. No result is delivered and all outputs take reset values.
- Inputs are sampled only at the accept edge. Changes to A/B/Sel afterwards, including during MUL, do not affect the result.

## Test plan
- ADD, WIDTH=8, A=0xFF, B=0x01, Out_ready=1: one cycle later Out=0x00, Zero=1, Carry=1, Overflow=0, Negative=0, Out_valid=1.
- SUB A=0x80, B=0x01: Out=0x7F, Overflow=1, Carry=0, Negative=0. Then SRA A=0x90, B=0x02: Out=0xE4, Negative=1.
- MUL A=0x12, B=0x10: Out_valid rises exactly 8 cycles after accept with Out=0x20 and Carry=1. In_ready stays 0 throughout, and changing A/B mid-multiply does not alter the result.
- Back-pressure: AND A=0xF0, B=0x3C with Out_ready=0 for 3 cycles. Out=0x30 is stable, In_ready=0, and a pending XOR is held. On Out_ready=1 the XOR is accepted on the same edge and appears the next cycle.
- Illegal op: OR A=0x0F, B=0xF0 (Out=0xFF, Zero=0), then Sel=0100. The response has Out=0xFF, Zero=0 and Err=1. A following ADD 0x01+0x01 gives Out=0x02, Err=0.
- Reset mid-MUL: assert Rst 4 cycles into a MUL. Immediately Out_valid=0, Out=0x00, Zero=1 and In_ready=1. No stale result appears after release, and a following ADD 0x03+0x04 gives Out=0x07.
